uart_rx_fifo: RTL and testbench

Receive-side byte buffer that sits directly downstream of the UART receiver. It captures each 8-bit frame presented on the receiver's parallel data/valid outputs and stores it in a small circular FIFO. It presents bytes to the host logic through a first-word-fall-through valid/ready interface, and flags overflow when a frame arrives with no space.

---
 rtl/uart_rx_fifo.sv | 84 ++++++++
 tb/tb_uart_rx_fifo.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// UART receive byte buffer: edge-detected capture into a circular FWFT FIFO with sticky overflow.
// Optional almost_full output is built only when UART_RX_FIFO_AF_EN is defined.
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int AF_THRESH  = 6
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   rx_data,
  input  logic                    rx_valid,
  input  logic                    rd_ready,
  input  logic                    clr_ovf,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count,
`ifdef UART_RX_FIFO_AF_EN
  output logic                    almost_full,
`endif
  output logic                    overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         rd_ptr, wr_ptr;
  logic                  rx_valid_d;
  logic                  push, pop, wr_en, drop;
  logic [CW-1:0]         count_nxt;

  assign push  = rx_valid & ~rx_valid_d;
  assign pop   = rd_valid & rd_ready;
  // A pop on the same edge frees the head slot, so a full FIFO can still accept.
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign rd_valid = ~empty;
  assign rd_data  = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({wr_en, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      rx_valid_d <= 1'b0;
    end else begin
      rx_valid_d <= rx_valid;
      count      <= count_nxt;
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      // A drop on the same edge as a clear keeps the flag set.
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

`ifdef UART_RX_FIFO_AF_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) almost_full <= 1'b0;
    else     almost_full <= (count_nxt >= CW'(AF_THRESH));
  end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo with hand-computed expectations.
module tb_uart_rx_fifo;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] rx_data;
  logic       rx_valid, rd_ready, clr_ovf;
  logic [7:0] rd_data;
  logic       rd_valid, full, empty, overflow;
  logic [3:0] count;
`ifdef UART_RX_FIFO_AF_EN
  logic       almost_full;
`endif

  int total = 0;
  int bad   = 0;

  uart_rx_fifo #(.DATA_WIDTH(8), .DEPTH(8), .AF_THRESH(6)) dut (
    .CLK(CLK), .RST(RST), .rx_data(rx_data), .rx_valid(rx_valid),
    .rd_ready(rd_ready), .clr_ovf(clr_ovf), .rd_data(rd_data),
    .rd_valid(rd_valid), .full(full), .empty(empty), .count(count),
`ifdef UART_RX_FIFO_AF_EN
    .almost_full(almost_full),
`endif
    .overflow(overflow)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Single-cycle rx_valid pulse followed by one idle cycle.
  task automatic push_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nsent, nread;
    RST = 1'b1; rx_data = '0; rx_valid = 0; rd_ready = 0; clr_ovf = 0;
    tick(); tick();
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0);
    RST = 1'b0;
    tick();

    // single push, FWFT latency, pop
    rx_data = 8'hA5; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    chk("a5_valid", rd_valid, 1);
    chk("a5_data", rd_data, 8'hA5);
    chk("a5_count", count, 1);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk("a5_pop_empty", empty, 1);
    chk("a5_pop_count", count, 0);

    // held rx_valid yields one write
    rx_data = 8'h3C; rx_valid = 1'b1;
    repeat (5) tick();
    rx_valid = 1'b0;
    tick();
    chk("hold_count", count, 1);
    chk("hold_data", rd_data, 8'h3C);
    rd_ready = 1'b1; tick(); rd_ready = 1'b0;
    chk("hold_drain", count, 0);

    // fill, overflow, drain in order, clear
    for (int i = 1; i <= 8; i++) push_byte(8'(i));
    chk("fill_full", full, 1);
    chk("fill_count", count, 8);
    chk("fill_ovf0", overflow, 0);
    push_byte(8'h09);
    chk("drop_ovf", overflow, 1);
    chk("drop_count", count, 8);
    rd_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("drain_%0d", i), rd_data, 8'(i));
      tick();
    end
    rd_ready = 1'b0;
    chk("drain_empty", empty, 1);
    chk("drain_ovf_sticky", overflow, 1);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    chk("clr_ovf", overflow, 0);

    // drop coincident with clear: set wins
    for (int i = 0; i < 8; i++) push_byte(8'hB0 + 8'(i));
    rx_data = 8'h77; rx_valid = 1'b1; clr_ovf = 1'b1;
    tick();
    rx_valid = 1'b0; clr_ovf = 1'b0;
    chk("set_wins", overflow, 1);
    tick();
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    chk("clr_again", overflow, 0);

    // push with pop while full
    rx_data = 8'h55; rx_valid = 1'b1; rd_ready = 1'b1;
    tick();
    rx_valid = 1'b0; rd_ready = 1'b0;
    chk("fullpp_count", count, 8);
    chk("fullpp_ovf", overflow, 0);
    chk("fullpp_head", rd_data, 8'hB1);
    tick();
    rd_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      chk($sformatf("fullpp_drain_%0d", i), rd_data, 8'hB0 + 8'(i));
      tick();
    end
    chk("fullpp_last", rd_data, 8'h55);
    tick();
    rd_ready = 1'b0;
    chk("fullpp_empty", empty, 1);

    // stream 20 bytes with toggling rd_ready
    nsent = 0; nread = 0;
    for (int c = 0; c < 400 && nread < 20; c++) begin
      if (c % 2 == 0 && nsent < 20) begin
        rx_valid = 1'b1; rx_data = 8'h10 + 8'(nsent); nsent++;
      end else rx_valid = 1'b0;
      rd_ready = (c % 4) < 2;
      if (rd_valid && rd_ready) begin
        chk($sformatf("stream_%0d", nread), rd_data, 8'h10 + 8'(nread));
        nread++;
      end
      tick();
    end
    rx_valid = 1'b0; rd_ready = 1'b0;
    chk("stream_nread", nread, 20);
    chk("stream_ovf", overflow, 0);
    chk("stream_empty", empty, 1);

    // async reset mid-cycle with 4 entries
    for (int i = 0; i < 4; i++) push_byte(8'hC0 + 8'(i));
    chk("pre_rst_count", count, 4);
    #3;
    RST = 1'b1;
    #1;
    chk("arst_empty", empty, 1);
    chk("arst_count", count, 0);
    chk("arst_ovf", overflow, 0);
    chk("arst_valid", rd_valid, 0);
    tick();
    RST = 1'b0;
    tick();

`ifdef UART_RX_FIFO_AF_EN
    for (int i = 0; i < 5; i++) push_byte(8'(i));
    chk("af_5", almost_full, 0);
    push_byte(8'h05);
    chk("af_6", almost_full, 1);
    rd_ready = 1'b1; tick(); rd_ready = 1'b0;
    chk("af_pop", almost_full, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
